// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: widths, opcode encodings, opcode classing
// and the reorder-buffer entry layout.
package tomasulo_pkg;

    localparam int DEPTH  = 8;
    localparam int TAG_W  = 3;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;
    localparam int DATA_W = 16;

    localparam logic [FUNC_W-1:0] OP_ADD = 4'b0000;
    localparam logic [FUNC_W-1:0] OP_SUB = 4'b0001;
    localparam logic [FUNC_W-1:0] OP_MUL = 4'b0010;
    localparam logic [FUNC_W-1:0] OP_DIV = 4'b0011;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispred;
        logic [FUNC_W-1:0] func;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    // Arithmetic ops write rd; every other encoding is a branch.
    function automatic logic is_writer(input logic [FUNC_W-1:0] func);
        return func[FUNC_W-1:FUNC_W-2] == 2'b00;
    endfunction

endpackage

// File: rtl/rob_ptr_ctr.sv
// Head/tail pointers and occupancy counter for the reorder buffer.
// Pointers wrap naturally at DEPTH; count tells full apart from empty.
module rob_ptr_ctr #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             inc_tail,
    input  logic             inc_head,
    input  logic             clear,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (inc_tail) tail <= tail + TAG_W'(1);
            if (inc_head) head <= head + TAG_W'(1);
            case ({inc_tail, inc_head})
                2'b10:   count <= count + (TAG_W+1)'(1);
                2'b01:   count <= count - (TAG_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (TAG_W+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order allocate, out-of-order complete from
// the CDB, in-order retire, and full flush on a mispredicted branch at head.
module rob_ctrl #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_req,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispred,
    output logic              commit_valid,
    output logic              commit_wen,
    output logic [REG_W-1:0]  commit_rd,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [DATA_W-1:0] commit_data,
    output logic              flush,
    output logic [TAG_W:0]    count,
    output logic              full,
    output logic              empty
);
    import tomasulo_pkg::*;

    rob_entry_t       rob [DEPTH];
    rob_entry_t       head_entry;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             commit_now;
    logic             flush_now;

    assign head_entry = rob[head];
    assign commit_now = head_entry.valid & head_entry.done;
    assign flush_now  = commit_now & head_entry.mispred & ~is_writer(head_entry.func);
    assign alloc_gnt  = alloc_req & ~full & ~flush_now;
    assign alloc_tag  = tail;

    rob_ptr_ctr #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_ptr (
        .clk1     (clk1),
        .rst      (rst),
        .inc_tail (alloc_gnt),
        .inc_head (commit_now),
        .clear    (flush_now),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // Commit, CDB write and allocate never target the same entry on one edge:
    // commit needs done, CDB needs not-done, and allocate needs a free slot.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            // NOTE: the whole entry array is reset so no stale done/mispred bit can survive into a new allocation.
            for (int i = 0; i < DEPTH; i++) rob[i] <= '0;
        end else if (flush_now) begin
            for (int i = 0; i < DEPTH; i++) rob[i].valid <= 1'b0;
        end else begin
            if (commit_now) rob[head].valid <= 1'b0;
            if (cdb_valid && rob[cdb_tag].valid && !rob[cdb_tag].done) begin
                rob[cdb_tag].done    <= 1'b1;
                rob[cdb_tag].data    <= cdb_data;
                rob[cdb_tag].mispred <= cdb_mispred;
            end
            if (alloc_gnt) begin
                rob[tail] <= '{valid: 1'b1, done: 1'b0, mispred: 1'b0,
                               func: alloc_func, rd: alloc_rd, data: '0};
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_rd    <= '0;
            commit_tag   <= '0;
            commit_data  <= '0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= commit_now;
            commit_wen   <= commit_now & is_writer(head_entry.func);
            flush        <= flush_now;
            if (commit_now) begin
                commit_rd   <= head_entry.rd;
                commit_tag  <= head;
                commit_data <= head_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Scoreboard bench for rob_ctrl: expected retirements are queued at allocate
// time and matched against the registered commit port in retire order.
module tb_rob_ctrl;

    localparam int TAG_W  = 3;
    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;
    localparam int DATA_W = 16;

    logic              clk1 = 1'b0;
    logic              rst  = 1'b1;
    logic              alloc_req   = 1'b0;
    logic [FUNC_W-1:0] alloc_func  = '0;
    logic [REG_W-1:0]  alloc_rd    = '0;
    logic              alloc_gnt;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cdb_valid   = 1'b0;
    logic [TAG_W-1:0]  cdb_tag     = '0;
    logic [DATA_W-1:0] cdb_data    = '0;
    logic              cdb_mispred = 1'b0;
    logic              commit_valid;
    logic              commit_wen;
    logic [REG_W-1:0]  commit_rd;
    logic [TAG_W-1:0]  commit_tag;
    logic [DATA_W-1:0] commit_data;
    logic              flush;
    logic [TAG_W:0]    count;
    logic              full;
    logic              empty;

    always #5 clk1 = ~clk1;

    rob_ctrl dut (
        .clk1         (clk1),
        .rst          (rst),
        .alloc_req    (alloc_req),
        .alloc_func   (alloc_func),
        .alloc_rd     (alloc_rd),
        .alloc_gnt    (alloc_gnt),
        .alloc_tag    (alloc_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .cdb_mispred  (cdb_mispred),
        .commit_valid (commit_valid),
        .commit_wen   (commit_wen),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush        (flush),
        .count        (count),
        .full         (full),
        .empty        (empty)
    );

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
        logic              wen;
    } exp_t;

    exp_t sb [$];
    int   commit_cycles [$];
    int   checks       = 0;
    int   errors       = 0;
    int   cyc          = 0;
    int   flush_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Commit monitor: every retire must match the oldest queued expectation.
    always @(negedge clk1) begin : monitor
        exp_t e;
        if (!rst) begin
            cyc++;
            if (flush) flush_cycles++;
            if (commit_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_commit", 32'(commit_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    commit_cycles.push_back(cyc);
                    check("commit_tag",  32'(commit_tag),  32'(e.tag));
                    check("commit_rd",   32'(commit_rd),   32'(e.rd));
                    check("commit_data", 32'(commit_data), 32'(e.data));
                    check("commit_wen",  32'(commit_wen),  32'(e.wen));
                end
            end
        end
    end

    task automatic next();
        @(negedge clk1);
        alloc_req   = 1'b0;
        cdb_valid   = 1'b0;
        cdb_mispred = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] func, input logic [3:0] rd, input int exp_tag,
                            input logic [15:0] data, input bit push);
        next();
        alloc_req  = 1'b1;
        alloc_func = func;
        alloc_rd   = rd;
        #1;
        check("alloc_gnt", 32'(alloc_gnt), 32'd1);
        check("alloc_tag", 32'(alloc_tag), 32'(exp_tag));
        if (push) sb.push_back('{tag: TAG_W'(exp_tag), rd: rd, data: data, wen: (func[3:2] == 2'b00)});
    endtask

    task automatic do_cdb(input int tag, input logic [15:0] data, input logic mp);
        next();
        cdb_valid   = 1'b1;
        cdb_tag     = TAG_W'(tag);
        cdb_data    = data;
        cdb_mispred = mp;
    endtask

    task automatic wait_sb(input int left, input int budget);
        int n = 0;
        while (sb.size() > left && n < budget) begin
            next();
            #1;
            n++;
        end
        check("sb_wait", 32'(sb.size()), 32'(left));
    endtask

    task automatic check_reset_outputs();
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_commit_wen",   32'(commit_wen),   32'd0);
        check("rst_flush",        32'(flush),        32'd0);
        check("rst_commit_rd",    32'(commit_rd),    32'd0);
        check("rst_commit_tag",   32'(commit_tag),   32'd0);
        check("rst_commit_data",  32'(commit_data),  32'd0);
        check("rst_count",        32'(count),        32'd0);
        check("rst_empty",        32'(empty),        32'd1);
        check("rst_full",         32'(full),         32'd0);
        check("rst_alloc_tag",    32'(alloc_tag),    32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst         = 1'b1;
        alloc_req   = 1'b0;
        cdb_valid   = 1'b0;
        cdb_mispred = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk1);
        rst = 1'b0;
    endtask

    int order [7] = '{3, 1, 7, 2, 5, 4, 6};

    initial begin
        repeat (2) @(negedge clk1);
        #1;
        check_reset_outputs();
        @(negedge clk1);
        rst = 1'b0;

        // Out-of-order completion, in-order back-to-back retirement.
        commit_cycles.delete();
        do_alloc(4'b0000, 4'd1, 0, 16'h000C, 1'b1);
        do_alloc(4'b0001, 4'd2, 1, 16'h000B, 1'b1);
        do_alloc(4'b0010, 4'd3, 2, 16'h000A, 1'b1);
        do_cdb(2, 16'h000A, 1'b0);
        do_cdb(1, 16'h000B, 1'b0);
        do_cdb(0, 16'h000C, 1'b0);
        wait_sb(0, 20);
        check("commit_n", 32'(commit_cycles.size()), 32'd3);
        if (commit_cycles.size() == 3) begin
            check("commit_gap01", 32'(commit_cycles[1] - commit_cycles[0]), 32'd1);
            check("commit_gap12", 32'(commit_cycles[2] - commit_cycles[1]), 32'd1);
        end

        // Fill to full, refuse while full, then wrap the tail.
        do_reset();
        for (int i = 0; i < 8; i++) do_alloc(4'b0000, 4'(i + 1), i, 16'(16'h100 + i), 1'b1);
        next();
        check("count_full", 32'(count), 32'd8);
        check("full_flag",  32'(full),  32'd1);
        check("empty_flag", 32'(empty), 32'd0);
        alloc_req = 1'b1;
        alloc_rd  = 4'hF;
        #1;
        check("gnt_when_full", 32'(alloc_gnt), 32'd0);
        next();
        check("count_hold", 32'(count), 32'd8);
        do_cdb(0, 16'h0100, 1'b0);
        next();
        alloc_req  = 1'b1;
        alloc_func = 4'b0001;
        alloc_rd   = 4'd9;
        #1;
        check("gnt_full_commit", 32'(alloc_gnt), 32'd0);
        next();
        check("count_after_commit", 32'(count), 32'd7);
        check("full_after_commit",  32'(full),  32'd0);
        do_alloc(4'b0001, 4'd9, 0, 16'h0200, 1'b1);
        next();
        check("count_refill", 32'(count), 32'd8);
        foreach (order[k]) do_cdb(order[k], 16'(16'h100 + order[k]), 1'b0);
        do_cdb(0, 16'h0200, 1'b0);
        wait_sb(0, 40);
        check("count_drained", 32'(count), 32'd0);
        check("empty_drained", 32'(empty), 32'd1);

        // Mispredicted branch at head flushes younger completed entries.
        do_reset();
        flush_cycles = 0;
        do_alloc(4'b0000, 4'd1, 0, 16'h0010, 1'b1);
        do_alloc(4'b0010, 4'd2, 1, 16'h0011, 1'b1);
        do_alloc(4'b0011, 4'd3, 2, 16'h0012, 1'b1);
        do_alloc(4'b0100, 4'd5, 3, 16'h0013, 1'b1);
        do_alloc(4'b0000, 4'd6, 4, 16'h0000, 1'b0);
        do_alloc(4'b0001, 4'd7, 5, 16'h0000, 1'b0);
        do_cdb(5, 16'h0055, 1'b0);
        do_cdb(4, 16'h0044, 1'b0);
        do_cdb(0, 16'h0010, 1'b0);
        do_cdb(1, 16'h0011, 1'b1);
        do_cdb(2, 16'h0012, 1'b0);
        do_cdb(3, 16'h0013, 1'b1);
        wait_sb(0, 20);
        repeat (6) next();
        #1;
        check("flush_pulses",    32'(flush_cycles), 32'd1);
        check("count_flush",     32'(count),        32'd0);
        check("empty_flush",     32'(empty),        32'd1);
        check("alloc_tag_flush", 32'(alloc_tag),    32'd0);

        // CDB to an invalid tag is ignored; the later allocation waits for its own write.
        do_cdb(6, 16'hFFFF, 1'b0);
        repeat (3) next();
        check("count_stray_cdb", 32'(count), 32'd0);
        check("empty_stray_cdb", 32'(empty), 32'd1);
        for (int i = 0; i < 7; i++) do_alloc(4'b0000, 4'(i + 1), i, 16'(16'h20 + i), 1'b1);
        for (int i = 0; i < 6; i++) do_cdb(i, 16'(16'h20 + i), 1'b0);
        wait_sb(1, 20);
        repeat (4) next();
        check("tag6_pending", 32'(sb.size()), 32'd1);
        check("count_tag6",   32'(count),     32'd1);
        do_cdb(6, 16'h0026, 1'b0);
        wait_sb(0, 10);

        // Asynchronous reset mid-stream with five entries in flight.
        do_alloc(4'b0000, 4'd1, 7, 16'h0077, 1'b1);
        do_alloc(4'b0000, 4'd2, 0, 16'h0000, 1'b0);
        do_alloc(4'b0000, 4'd3, 1, 16'h0000, 1'b0);
        do_alloc(4'b0000, 4'd4, 2, 16'h0000, 1'b0);
        do_alloc(4'b0000, 4'd5, 3, 16'h0000, 1'b0);
        do_cdb(7, 16'h0077, 1'b0);
        next();
        next();
        #1;
        check("pre_rst_commit", 32'(commit_valid), 32'd1);
        check("pre_rst_count",  32'(count),        32'd4);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        next();
        rst = 1'b0;
        do_alloc(4'b0000, 4'd1, 0, 16'h0000, 1'b0);
        next();
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
